// File: rtl/imm_decode_ctrl.sv
// imm_decode_ctrl: decode-stage sequencer for the shared immediate generator.
// Accepts RISC-V instruction words, classifies the opcode into the generator's
// type select, drives the generator for one cycle, captures the immediate and
// presents instruction, immediate and decode flags downstream.
// Also keeps a saturating count of accepted illegal instructions.
module imm_decode_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ins,
  output logic [31:0]      gen_ins,
  output logic [2:0]       gen_sel,
  input  logic [31:0]      gen_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_ins,
  output logic [31:0]      out_imm,
  output logic [2:0]       out_sel,
  output logic             out_has_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam logic [2:0] SEL_I = 3'b000;
  localparam logic [2:0] SEL_S = 3'b001;
  localparam logic [2:0] SEL_B = 3'b010;
  localparam logic [2:0] SEL_U = 3'b011;
  localparam logic [2:0] SEL_J = 3'b100;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [31:0]      ins_q, ins_d;
  logic [2:0]       sel_q, sel_d;
  logic             has_imm_q, has_imm_d;
  logic             illegal_q, illegal_d;
  logic [31:0]      imm_q, imm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]       dec_sel;
  logic             dec_has_imm;
  logic             dec_illegal;
  logic             accept;

  // Opcode classification of the incoming word.
  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    dec_sel     = SEL_I;
    dec_has_imm = 1'b0;
    dec_illegal = 1'b0;
    // Every listed opcode ends in 2'b11, so a word with ins[1:0]!=11 falls
    // into the default branch and is flagged illegal.
    case (in_ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_sel     = SEL_I;
        dec_has_imm = 1'b1;
      end
      7'b0100011: begin
        dec_sel     = SEL_S;
        dec_has_imm = 1'b1;
      end
      7'b1100011: begin
        dec_sel     = SEL_B;
        dec_has_imm = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        dec_sel     = SEL_U;
        dec_has_imm = 1'b1;
      end
      7'b1101111: begin
        dec_sel     = SEL_J;
        dec_has_imm = 1'b1;
      end
      7'b0110011: begin
        dec_sel     = SEL_I;
        dec_has_imm = 1'b0;
      end
      default: begin
        dec_sel     = SEL_I;
        dec_has_imm = 1'b0;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Handshake outputs and register views; in_ready is purely combinational.
  always_comb begin
    in_ready    = !rst && !flush &&
                  ((state_q == IDLE) || ((state_q == OUT) && out_ready));
    out_valid   = (state_q == OUT);
    gen_ins     = ins_q;
    gen_sel     = sel_q;
    out_ins     = ins_q;
    out_imm     = imm_q;
    out_sel     = sel_q;
    out_has_imm = has_imm_q;
    out_illegal = illegal_q;
    illegal_cnt = cnt_q;
  end

  assign accept = in_valid && in_ready;

  // Next-state logic; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = GEN;
      GEN:     state_d = OUT;
      OUT:     if (out_ready) state_d = accept ? GEN : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Datapath next values: latch decode on accept, capture immediate in GEN.
  always_comb begin
    ins_d     = ins_q;
    sel_d     = sel_q;
    has_imm_d = has_imm_q;
    illegal_d = illegal_q;
    imm_d     = imm_q;
    cnt_d     = cnt_q;
    if (accept) begin
      ins_d     = in_ins;
      sel_d     = dec_sel;
      has_imm_d = dec_has_imm;
      illegal_d = dec_illegal;
      if (dec_illegal && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
    end
    if (state_q == GEN) imm_d = has_imm_q ? gen_imm : 32'h0;
  end

  // State and datapath registers with synchronous active-high reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ins_q     <= 32'h0;
      sel_q     <= SEL_I;
      has_imm_q <= 1'b0;
      illegal_q <= 1'b0;
      imm_q     <= 32'h0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ins_q     <= ins_d;
      sel_q     <= sel_d;
      has_imm_q <= has_imm_d;
      illegal_q <= illegal_d;
      imm_q     <= imm_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Self-checking bench for imm_decode_ctrl. Two instances share stimulus: a
// CNT_W=16 unit that is fully checked and a CNT_W=2 unit whose counter is
// checked for saturation. The immediate generator is modelled behaviourally.
module tb_imm_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_ins;

  logic        in_ready, out_valid, out_has_imm, out_illegal;
  logic [31:0] gen_ins, gen_imm, out_ins, out_imm;
  logic [2:0]  gen_sel, out_sel;
  logic [15:0] illegal_cnt;

  logic        in_ready2, out_valid2, out_has_imm2, out_illegal2;
  logic [31:0] gen_ins2, gen_imm2, out_ins2, out_imm2;
  logic [2:0]  gen_sel2, out_sel2;
  logic [1:0]  illegal_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic       has_imm;
    logic       illegal;
  } dec_t;

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  sel;
    logic        has_imm;
    logic        illegal;
    logic [31:0] imm;
  } vec_t;

  // Immediate generator as defined by the RISC-V base formats.
  function automatic logic [31:0] imm_gen(input logic [31:0] i, input logic [2:0] s);
    case (s)
      3'b000:  return {{20{i[31]}}, i[31:20]};
      3'b001:  return {{20{i[31]}}, i[31:25], i[11:7]};
      3'b010:  return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'b011:  return {i[31:12], 12'h000};
      3'b100:  return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  assign gen_imm  = imm_gen(gen_ins, gen_sel);
  assign gen_imm2 = imm_gen(gen_ins2, gen_sel2);

  imm_decode_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ins(in_ins), .gen_ins(gen_ins), .gen_sel(gen_sel), .gen_imm(gen_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins), .out_imm(out_imm),
    .out_sel(out_sel), .out_has_imm(out_has_imm), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  imm_decode_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_ins(in_ins), .gen_ins(gen_ins2), .gen_sel(gen_sel2), .gen_imm(gen_imm2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_ins(out_ins2), .out_imm(out_imm2),
    .out_sel(out_sel2), .out_has_imm(out_has_imm2), .out_illegal(out_illegal2),
    .illegal_cnt(illegal_cnt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Opcode table from the instruction set's format classes.
  function automatic dec_t tb_decode(input logic [31:0] ins);
    dec_t d;
    d = '{sel: 3'b000, has_imm: 1'b0, illegal: 1'b1};
    case (ins[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: d = '{3'b000, 1'b1, 1'b0};
      7'h23:                      d = '{3'b001, 1'b1, 1'b0};
      7'h63:                      d = '{3'b010, 1'b1, 1'b0};
      7'h37, 7'h17:               d = '{3'b011, 1'b1, 1'b0};
      7'h6F:                      d = '{3'b100, 1'b1, 1'b0};
      7'h33:                      d = '{3'b000, 1'b0, 1'b0};
      default:                    d = '{3'b000, 1'b0, 1'b1};
    endcase
    return d;
  endfunction

  // Transaction-level reference: one held item and its age since acceptance.
  bit          m_have  = 0;
  bit          m_shown = 0;   // item has finished its generate cycle
  bit          m_fresh = 1;   // nothing accepted since reset
  logic [31:0] m_ins   = 0;
  logic [31:0] m_last  = 0;
  int          m_cnt16 = 0;
  int          m_cnt2  = 0;
  bit          m_acc;

  task automatic model_check();
    bit   exp_ready, exp_valid;
    dec_t d, dl;
    exp_ready = !rst && !flush && (!m_have || (m_shown && out_ready));
    exp_valid = m_have && m_shown;
    m_acc     = in_valid && exp_ready;
    dl        = tb_decode(m_last);
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, exp_valid);
    check("illegal_cnt", illegal_cnt, m_cnt16);
    check("illegal_cnt_w2", illegal_cnt2, m_cnt2);
    check("gen_ins", gen_ins, m_last);
    check("gen_sel", gen_sel, dl.sel);
    if (exp_valid) begin
      d = tb_decode(m_ins);
      check("out_ins", out_ins, m_ins);
      check("out_sel", out_sel, d.sel);
      check("out_has_imm", out_has_imm, d.has_imm);
      check("out_illegal", out_illegal, d.illegal);
      check("out_imm", out_imm, d.has_imm ? imm_gen(m_ins, d.sel) : 32'h0);
    end else if (m_fresh) begin
      check("rst_out_ins", out_ins, 32'h0);
      check("rst_out_imm", out_imm, 32'h0);
      check("rst_out_sel", out_sel, 3'b000);
      check("rst_out_flags", {out_has_imm, out_illegal}, 2'b00);
    end
  endtask

  task automatic model_update();
    dec_t d;
    if (rst) begin
      m_have = 0; m_fresh = 1; m_last = 0; m_cnt16 = 0; m_cnt2 = 0;
    end else if (flush) begin
      m_have = 0;
    end else if (m_acc) begin
      d = tb_decode(in_ins);
      m_have = 1; m_shown = 0; m_ins = in_ins; m_last = in_ins; m_fresh = 0;
      if (d.illegal) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end else if (m_have && m_shown && out_ready) begin
      m_have = 0;
    end else if (m_have) begin
      m_shown = 1;
    end
  endtask

  // Apply inputs for one cycle and check against the model mid-cycle.
  task automatic drive(input logic r, input logic v, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    rst = r; in_valid = v; in_ins = ins; out_ready = ordy; flush = fl;
    @(negedge clk);
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  vec_t tbl[$];
  logic [31:0] ill_words[5];
  int exp_c2[5];

  initial begin
    tbl.push_back('{32'h00400113, 3'b000, 1'b1, 1'b0, 32'h00000004}); // ADDI
    tbl.push_back('{32'h00112623, 3'b001, 1'b1, 1'b0, 32'h0000000C}); // SW
    tbl.push_back('{32'h123452B7, 3'b011, 1'b1, 1'b0, 32'h12345000}); // LUI
    tbl.push_back('{32'h0080006F, 3'b100, 1'b1, 1'b0, 32'h00000008}); // JAL
    tbl.push_back('{32'hFE000EE3, 3'b010, 1'b1, 1'b0, 32'hFFFFFFFC}); // BEQ -4
    tbl.push_back('{32'hFFFFF097, 3'b011, 1'b1, 1'b0, 32'hFFFFF000}); // AUIPC
    tbl.push_back('{32'hFFC12083, 3'b000, 1'b1, 1'b0, 32'hFFFFFFFC}); // LW -4
    tbl.push_back('{32'h002081B3, 3'b000, 1'b0, 1'b0, 32'h00000000}); // ADD
    tbl.push_back('{32'h00000000, 3'b000, 1'b0, 1'b1, 32'h00000000}); // zero word
    tbl.push_back('{32'h00400112, 3'b000, 1'b0, 1'b1, 32'h00000000}); // ins[1:0]=10
    ill_words = '{32'h00000000, 32'hFFFFFFFF, 32'h0000007F, 32'h00400111, 32'h0000000B};
    exp_c2    = '{1, 2, 3, 3, 3};

    rst = 1; flush = 0; in_valid = 0; in_ins = 0; out_ready = 0;
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0); tick();

    // Back-to-back stream: accept, one generate cycle, then present while
    // accepting the next word in the same cycle.
    drive(0, 1, tbl[0].ins, 1, 0); tick();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(0, 0, 0, 1, 0);
      check("tbl_gen_sel", gen_sel, tbl[i].sel);
      check("tbl_gen_ins", gen_ins, tbl[i].ins);
      check("tbl_valid_in_gen", out_valid, 1'b0);
      tick();
      drive(0, (i < tbl.size() - 1), (i < tbl.size() - 1) ? tbl[i+1].ins : 32'h0, 1, 0);
      check("tbl_out_valid", out_valid, 1'b1);
      check("tbl_in_ready", in_ready, 1'b1);
      check("tbl_out_ins", out_ins, tbl[i].ins);
      check("tbl_out_sel", out_sel, tbl[i].sel);
      check("tbl_out_has_imm", out_has_imm, tbl[i].has_imm);
      check("tbl_out_illegal", out_illegal, tbl[i].illegal);
      check("tbl_out_imm", out_imm, tbl[i].imm);
      tick();
    end
    drive(0, 0, 0, 1, 0);
    check("tbl_illegal_cnt", illegal_cnt, 16'd2);
    tick();

    // Backpressure: three stalled cycles, then accept alongside the handshake.
    drive(0, 1, 32'h00400113, 1, 0); tick();
    drive(0, 0, 0, 0, 0); tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 32'h00112623, 0, 0);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_ins", out_ins, 32'h00400113);
      check("bp_out_imm", out_imm, 32'h00000004);
      tick();
    end
    drive(0, 1, 32'h00112623, 1, 0);
    check("bp_release_ready", in_ready, 1'b1);
    tick();
    drive(0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 1, 0);
    check("bp_next_imm", out_imm, 32'h0000000C);
    tick();

    // Flush during generate, then flush with a valid word while idle.
    drive(0, 1, 32'h00400113, 1, 0); tick();
    drive(0, 0, 0, 1, 1);
    check("fl_ready_low", in_ready, 1'b0);
    tick();
    drive(0, 1, 32'h123452B7, 1, 1);
    check("fl_no_valid", out_valid, 1'b0);
    check("fl_idle_ready_low", in_ready, 1'b0);
    tick();
    drive(0, 0, 0, 1, 0);
    check("fl_still_no_valid", out_valid, 1'b0);
    check("fl_ready_back", in_ready, 1'b1);
    check("fl_gen_ins_held", gen_ins, 32'h00400113);
    tick();

    // Narrow counter saturation, starting from reset.
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 1, ill_words[0], 1, 0); tick();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 1, 0);
      check("sat_cnt_w2", illegal_cnt2, exp_c2[k]);
      tick();
      drive(0, (k < 4), (k < 4) ? ill_words[k+1] : 32'h0, 1, 0); tick();
    end
    drive(0, 0, 0, 1, 0);
    check("sat_cnt_w16", illegal_cnt, 16'd5);
    tick();

    // Reset while presenting a result.
    drive(0, 1, 32'h00400113, 0, 0); tick();
    drive(0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0);
    check("rst_in_ready", in_ready, 1'b0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_out_ins", out_ins, 32'h0);
    check("rst_mid_out_imm", out_imm, 32'h0);
    check("rst_mid_gen", {gen_ins, gen_sel}, 35'h0);
    check("rst_mid_cnt", illegal_cnt, 16'd0);
    check("rst_mid_cnt_w2", illegal_cnt2, 2'd0);
    tick();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      logic [6:0]  ops[11];
      logic [31:0] w;
      ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};
      w = $urandom();
      if ($urandom_range(0, 7) != 0) w = (w & 32'hFFFF_FF80) | {25'h0, ops[$urandom_range(0, 10)]};
      drive($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, w,
            $urandom_range(0, 2) != 0, $urandom_range(0, 20) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
